// File: rtl/audio_udp_pkg.sv
// Shared types and constants for the UDP audio receive path.
// State encodings are one-hot to match the other FSMs in the audio_udp codebase.
package audio_udp_pkg;

    localparam int SAMPLE_W        = 16;
    localparam int MAX_PAYLOAD_DEF = 1472;

    typedef enum logic [3:0] {
        RX_SYNC = 4'b0001,
        RX_IDLE = 4'b0010,
        RX_DATA = 4'b0100,
        RX_DROP = 4'b1000
    } rx_state_t;

    typedef enum logic [1:0] {
        PREFILL = 2'b01,
        PLAY    = 2'b10
    } pb_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/audio_sample_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a registered
// output (1-cycle latency). Written so it maps onto a Pango DRM block.
module audio_sample_ram
    import audio_udp_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [2**AW];

    // NOTE: the array has no reset; a reset would stop it mapping to block RAM, and buf_level gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_audio_depack.sv
// Unpacks big-endian UDP payload bytes into 16-bit PCM samples, buffers them in a
// circular jitter buffer and plays one sample out per sample_tick.
module udp_audio_depack
    import audio_udp_pkg::*;
#(
    parameter int BUF_AW        = 10,
    parameter int PREFILL_LEVEL = 480,
    parameter int MAX_PAYLOAD   = MAX_PAYLOAD_DEF
) (
    input  logic                rgmii_clk,
    input  logic                rst,
    input  logic                udp_rec_data_valid,
    input  logic [7:0]          udp_rec_rdata,
    input  logic [15:0]         udp_rec_data_length,
    input  logic                sample_tick,
    output logic [SAMPLE_W-1:0] pcm_out,
    output logic                pcm_valid,
    output logic                playing,
    output logic [BUF_AW:0]     buf_level,
    output logic [15:0]         underrun_cnt,
    output logic [15:0]         overflow_cnt
);

    localparam logic [BUF_AW:0] FULL_LEVEL = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [BUF_AW:0] START_LVL  = (BUF_AW+1)'(PREFILL_LEVEL);
    localparam logic [BUF_AW:0] LVL_ONE    = (BUF_AW+1)'(1);
    localparam logic [15:0]     MAX_LEN    = 16'(MAX_PAYLOAD);

    rx_state_t             rx_state, rx_next;
    pb_state_t             pb_state, pb_next;
    logic [15:0]           len_q, byte_cnt;
    logic [7:0]            hi_q;
    logic [BUF_AW-1:0]     wr_ptr, rd_ptr;
    logic [BUF_AW:0]       level;
    logic                  pkt_start, wr_req, wr_acc, ovf_drop, pkt_ovf;
    logic                  rd_en, underrun, from_ram, last_byte, buf_full;
    logic [SAMPLE_W-1:0]   ram_q;

    assign last_byte = (byte_cnt == len_q - 16'd1);
    assign buf_full  = (level == FULL_LEVEL);
    assign wr_acc    = wr_req & ~buf_full;
    assign ovf_drop  = wr_req & buf_full;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        rx_next   = rx_state;
        pkt_start = 1'b0;
        wr_req    = 1'b0;
        unique case (rx_state)
            RX_SYNC: if (!udp_rec_data_valid) rx_next = RX_IDLE;
            RX_IDLE: begin
                if (udp_rec_data_valid) begin
                    pkt_start = 1'b1;
                    if (udp_rec_data_length == 16'd0 || udp_rec_data_length > MAX_LEN) begin
                        rx_next = RX_DROP;
                    end else if (udp_rec_data_length != 16'd1) begin
                        rx_next = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (udp_rec_data_valid) begin
                    wr_req = byte_cnt[0];
                    if (last_byte) rx_next = RX_IDLE;
                end
            end
            RX_DROP: begin
                // A zero-length packet has no byte count to end on, so it runs until valid falls.
                if (len_q == 16'd0) begin
                    if (!udp_rec_data_valid) rx_next = RX_IDLE;
                end else if (udp_rec_data_valid && last_byte) begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_SYNC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            rx_state <= RX_SYNC;
            len_q    <= '0;
            byte_cnt <= '0;
            hi_q     <= '0;
        end else begin
            rx_state <= rx_next;
            if (pkt_start) begin
                len_q    <= udp_rec_data_length;
                byte_cnt <= 16'd1;
                hi_q     <= udp_rec_rdata;
            end else if (udp_rec_data_valid && (rx_state == RX_DATA || rx_state == RX_DROP)) begin
                byte_cnt <= byte_cnt + 16'd1;
                if (rx_state == RX_DATA && !byte_cnt[0]) hi_q <= udp_rec_rdata;
            end
        end
    end

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            pkt_ovf      <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (pkt_start) begin
                pkt_ovf <= 1'b0;
            end else if (ovf_drop) begin
                pkt_ovf <= 1'b1;
            end
            if (ovf_drop && !pkt_ovf) overflow_cnt <= sat_inc16(overflow_cnt);
        end
    end

    always_comb begin
        pb_next  = pb_state;
        rd_en    = 1'b0;
        underrun = 1'b0;
        unique case (pb_state)
            PREFILL: if (level >= START_LVL) pb_next = PLAY;
            PLAY: begin
                if (sample_tick) begin
                    if (level != '0) begin
                        rd_en = 1'b1;
                    end else begin
                        underrun = 1'b1;
                        pb_next  = PREFILL;
                    end
                end
            end
            default: pb_next = PREFILL;
        endcase
    end

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            pb_state     <= PREFILL;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            pcm_valid    <= 1'b0;
            from_ram     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            pb_state  <= pb_next;
            pcm_valid <= sample_tick;
            from_ram  <= rd_en;
            if (wr_acc) wr_ptr <= wr_ptr + BUF_AW'(1);
            if (rd_en)  rd_ptr <= rd_ptr + BUF_AW'(1);
            // Same-cycle read and write cancel out.
            unique case ({wr_acc, rd_en})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (underrun) underrun_cnt <= sat_inc16(underrun_cnt);
        end
    end

    audio_sample_ram #(.AW(BUF_AW)) u_ram (
        .clk     (rgmii_clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data ({hi_q, udp_rec_rdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // Prefill and underrun ticks output silence; only a real read shows RAM data.
    assign pcm_out   = from_ram ? ram_q : '0;
    assign playing   = (pb_state == PLAY);
    assign buf_level = level;

endmodule

// File: tb/tb_udp_audio_depack.sv
// Self-checking bench for udp_audio_depack: directed scenarios, a packet-length
// vector table and randomized traffic checked against a queue-based model.
module tb_udp_audio_depack;

    localparam int DEPTH   = 1024;
    localparam int PREFILL = 480;
    localparam int MAXP    = 1472;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        udp_rec_data_valid = 1'b0;
    logic [7:0]  udp_rec_rdata = '0;
    logic [15:0] udp_rec_data_length = '0;
    logic        sample_tick = 1'b0;
    logic [15:0] pcm_out;
    logic        pcm_valid;
    logic        playing;
    logic [10:0] buf_level;
    logic [15:0] underrun_cnt;
    logic [15:0] overflow_cnt;

    udp_audio_depack #(.BUF_AW(10), .PREFILL_LEVEL(PREFILL), .MAX_PAYLOAD(MAXP)) dut (
        .rgmii_clk           (clk),
        .rst                 (rst),
        .udp_rec_data_valid  (udp_rec_data_valid),
        .udp_rec_rdata       (udp_rec_rdata),
        .udp_rec_data_length (udp_rec_data_length),
        .sample_tick         (sample_tick),
        .pcm_out             (pcm_out),
        .pcm_valid           (pcm_valid),
        .playing             (playing),
        .buf_level           (buf_level),
        .underrun_cnt        (underrun_cnt),
        .overflow_cnt        (overflow_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a FIFO of samples plus the play/prefill flag and counters.
    logic [15:0] m_q[$];
    bit          m_play;
    int          m_under;
    int          m_ovf;

    typedef struct {
        int len;
        int nbytes;
        int exp_samples;
    } len_vec_t;

    len_vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_q.delete();
        m_play  = 1'b0;
        m_under = 0;
        m_ovf   = 0;
    endfunction

    function automatic void model_packet(input int len, input logic [7:0] b[$]);
        bit lost = 1'b0;
        if (len < 2 || len > MAXP) return;
        for (int i = 0; i + 1 < len; i += 2) begin
            if (m_q.size() < DEPTH) m_q.push_back({b[i], b[i+1]});
            else lost = 1'b1;
        end
        if (lost && m_ovf < 65535) m_ovf++;
        if (m_q.size() >= PREFILL) m_play = 1'b1;
    endfunction

    function automatic logic [15:0] model_tick();
        if (!m_play) return 16'h0000;
        if (m_q.size() > 0) return m_q.pop_front();
        if (m_under < 65535) m_under++;
        m_play = 1'b0;
        return 16'h0000;
    endfunction

    task automatic check_status(input string tag);
        check({tag, "/buf_level"}, 32'(buf_level), 32'(m_q.size()));
        check({tag, "/playing"}, 32'(playing), 32'(m_play));
        check({tag, "/underrun_cnt"}, 32'(underrun_cnt), 32'(m_under));
        check({tag, "/overflow_cnt"}, 32'(overflow_cnt), 32'(m_ovf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        udp_rec_data_valid = 1'b0;
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
    endtask

    // base < 0 gives random bytes, otherwise bytes base, base+1, ...
    task automatic send_pkt(input int len, input int nbytes, input int gap_pct, input int base);
        logic [7:0] b[$];
        for (int i = 0; i < nbytes; i++) b.push_back((base < 0) ? 8'($urandom) : 8'(base + i));
        for (int i = 0; i < nbytes; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                @(negedge clk);
                udp_rec_data_valid = 1'b0;
            end
            @(negedge clk);
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = b[i];
            udp_rec_data_length = (i == 0) ? 16'(len) : 16'($urandom);
        end
        @(negedge clk);
        udp_rec_data_valid  = 1'b0;
        udp_rec_data_length = '0;
        repeat (2) @(negedge clk);
        model_packet(len, b);
    endtask

    // n back-to-back ticks; each result is checked one cycle after its tick.
    task automatic tick_run(input int n, output logic [15:0] last);
        logic [15:0] exp;
        last = '0;
        @(negedge clk);
        sample_tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == n - 1) sample_tick = 1'b0;
            exp = model_tick();
            check("pcm_valid", 32'(pcm_valid), 32'd1);
            check("pcm_out", 32'(pcm_out), 32'(exp));
            last = pcm_out;
        end
        @(negedge clk);
        check("pcm_valid_pulse", 32'(pcm_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] last;
        int lv;

        vecs[0] = '{240, 240, 120};
        vecs[1] = '{241, 241, 120};
        vecs[2] = '{1500, 1500, 0};
        vecs[3] = '{0, 1, 0};
        vecs[4] = '{1, 1, 0};
        vecs[5] = '{2, 2, 1};
        vecs[6] = '{3, 3, 1};
        vecs[7] = '{1472, 1472, 736};
        vecs[8] = '{1473, 1473, 0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst/pcm_out", 32'(pcm_out), 32'd0);
        check("rst/pcm_valid", 32'(pcm_valid), 32'd0);
        check("rst/playing", 32'(playing), 32'd0);
        check("rst/buf_level", 32'(buf_level), 32'd0);
        check("rst/underrun_cnt", 32'(underrun_cnt), 32'd0);
        check("rst/overflow_cnt", 32'(overflow_cnt), 32'd0);
        rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);

        // Ticks before any data: silence, no underrun
        for (int i = 0; i < 3; i++) begin
            tick_run(1, last);
            check("empty/pcm_out", 32'(last), 32'd0);
        end
        check("empty/playing", 32'(playing), 32'd0);
        check("empty/underrun_cnt", 32'(underrun_cnt), 32'd0);

        // Prefill with 4 x 240-byte ramps, play out at one tick per 10 cycles
        for (int p = 0; p < 4; p++) begin
            send_pkt(240, 240, 0, 0);
            if (p == 2) check("prefill3/playing", 32'(playing), 32'd0);
        end
        check("prefill4/playing", 32'(playing), 32'd1);
        check("prefill4/buf_level", 32'(buf_level), 32'd480);
        for (int i = 0; i < 480; i++) begin
            tick_run(1, last);
            if (i == 0)   check("ramp/first", 32'(last), 32'h0001);
            if (i == 1)   check("ramp/second", 32'(last), 32'h0203);
            if (i == 119) check("ramp/last", 32'(last), 32'hEEEF);
            if (i == 120) check("ramp/repeat", 32'(last), 32'h0001);
            repeat (7) @(negedge clk);
        end
        check_status("drained");
        tick_run(1, last);
        check("underrun/pcm_out", 32'(last), 32'd0);
        check("underrun/underrun_cnt", 32'(underrun_cnt), 32'd1);
        check("underrun/playing", 32'(playing), 32'd0);
        for (int p = 0; p < 4; p++) send_pkt(240, 240, 0, 0);
        check("restart/playing", 32'(playing), 32'd1);
        tick_run(4, last);

        // Length handling table: each packet followed by a 4-byte probe packet
        foreach (vecs[k]) begin
            do_reset();
            send_pkt(vecs[k].len, vecs[k].nbytes, 0, 16);
            check($sformatf("len%0d/buf_level", vecs[k].len), 32'(buf_level), 32'(vecs[k].exp_samples));
            send_pkt(4, 4, 0, 0);
            check($sformatf("len%0d/next_pkt", vecs[k].len), 32'(buf_level), 32'(vecs[k].exp_samples + 2));
        end

        // Overflow: fill to 1024 exactly, then overflow twice
        do_reset();
        for (int p = 0; p < 8; p++) send_pkt(240, 240, 0, -1);
        send_pkt(128, 128, 0, -1);
        check("full/buf_level", 32'(buf_level), 32'd1024);
        check("full/overflow_cnt", 32'(overflow_cnt), 32'd0);
        send_pkt(240, 240, 0, -1);
        check("ovf1/buf_level", 32'(buf_level), 32'd1024);
        check("ovf1/overflow_cnt", 32'(overflow_cnt), 32'd1);
        send_pkt(240, 240, 0, -1);
        check("ovf2/overflow_cnt", 32'(overflow_cnt), 32'd2);
        tick_run(1024, last);
        check_status("ovf_drained");

        // Reset asserted mid-packet and released while valid is still high
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 240; i++) begin
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = 8'(8'hA0 + i);
            udp_rec_data_length = (i == 0) ? 16'd240 : 16'd2;
            if (i == 50) rst = 1'b1;
            if (i == 53) rst = 1'b0;
            @(negedge clk);
        end
        udp_rec_data_valid = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("midrst/buf_level", 32'(buf_level), 32'd0);
        for (int p = 0; p < 4; p++) send_pkt(240, 240, 0, 0);
        check("midrst/buf_level2", 32'(buf_level), 32'd480);
        tick_run(3, last);
        check("midrst/data", 32'(last), 32'h0405);

        // Randomized traffic against the model
        do_reset();
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(1) == 0) begin
                lv = $urandom_range(99);
                if (lv < 5)       send_pkt(0, $urandom_range(1, 3), 0, -1);
                else if (lv < 10) send_pkt(1, 1, 0, -1);
                else if (lv < 14) begin
                    lv = $urandom_range(1473, 1600);
                    send_pkt(lv, lv, 10, -1);
                end else begin
                    lv = $urandom_range(2, 300);
                    send_pkt(lv, lv, 20, -1);
                end
            end else if ($urandom_range(1) == 0) begin
                tick_run($urandom_range(1, 80), last);
            end else begin
                lv = $urandom_range(1, 20);
                for (int t = 0; t < lv; t++) begin
                    tick_run(1, last);
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                end
            end
            check_status($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
